miriscv_mdu_issue: RTL and testbench
====================================

MIRISCV_MDU_ISSUE -- requirements
Module: miriscv_mdu_issue

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of cycles in BUSY before the operation is aborted.
REQ-002 SHALL have parameter RD_W, default 5, meaning the width of the destination register index.
REQ-003 SHALL have port clk_i  in  1  clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port arstn_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ex_valid_i  in  1  execute stage presents an MDU instruction.
REQ-006 SHALL have port ex_op_i  in  MDU_OP_WIDTH  MDU opcode.
REQ-007 SHALL have ports ex_a_i, ex_b_i  in  XLEN  operands.
REQ-008 SHALL have port ex_rd_i  in  RD_W  destination register.
REQ-009 SHALL have port ex_flush_i  in  1  pipeline flush; cancels the in-flight operation.
REQ-010 SHALL have port wb_stall_i  in  1  writeback cannot accept a result.
REQ-011 SHALL have ports mdu_stall_req_i (1) and mdu_result_i (XLEN)  in  status and result from the MDU.
REQ-012 SHALL have ports mdu_req_o (1), mdu_op_o (MDU_OP_WIDTH), mdu_port_a_o (XLEN), mdu_port_b_o (XLEN), mdu_kill_o (1), mdu_keep_o (1)  out  MDU control.
REQ-013 SHALL have port issue_stall_o  out  1  execute must hold its instruction.
REQ-014 SHALL have ports wb_valid_o (1), wb_rd_o (RD_W), wb_data_o (XLEN), wb_err_o (1)  out  writeback result.

Function
REQ-015 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-016 SHALL, in IDLE, with ex_valid_i=1 and ex_flush_i=0: register op, a, b and rd, clear the cycle counter, and move to BUSY on the next edge.
REQ-017 SHALL drive mdu_req_o=1 only in BUSY; mdu_op_o and mdu_port_*_o SHALL come from the registered copies and stay stable throughout BUSY.
REQ-018 SHALL complete a BUSY cycle with mdu_stall_req_i=0 by capturing mdu_result_i into wb_data_o and moving to DONE; minimum latency is 2 cycles from issue to wb_valid_o.
REQ-019 SHALL, in DONE: drive wb_valid_o=1 and mdu_keep_o=1, and hold wb_data_o and wb_rd_o stable while wb_stall_i=1.
REQ-020 SHALL, in DONE with wb_stall_i=0: retire the result; if ex_valid_i=1 and ex_flush_i=0 in the same cycle, issue directly to BUSY (back-to-back), otherwise go to IDLE.
REQ-021 SHALL drive issue_stall_o = ex_valid_i AND NOT (state==IDLE OR (state==DONE AND wb_stall_i==0)).
REQ-022 SHALL give ex_flush_i priority over completion and new issue; in BUSY it drives mdu_kill_o=1 combinationally for that cycle and the next state is IDLE.
REQ-023 SHALL, on ex_flush_i in DONE, drop the result (no further wb_valid_o) and go to IDLE.
REQ-024 SHALL increment the cycle counter each BUSY cycle; the counter SHALL be sized clog2(TIMEOUT_CYCLES+1) and saturate at TIMEOUT_CYCLES.
REQ-025 SHALL, when the counter reaches TIMEOUT_CYCLES while still stalled: pulse mdu_kill_o, set wb_err_o=1 and wb_data_o=0, and enter DONE.
REQ-026 SHALL clear wb_err_o on the next issue.
REQ-027 SHALL keep mdu_kill_o=0 in IDLE and DONE, and mdu_keep_o=0 outside DONE.

Reset
REQ-028 SHALL, on arstn_i=0, immediately enter IDLE and zero all registers and the counter.
REQ-029 SHALL drive all outputs to 0 during reset, including mdu_req_o and wb_valid_o.
REQ-030 SHALL, on reset mid-operation, lose the in-flight instruction without producing any writeback.

Structure
REQ-031 SHALL place the state enum typedef mdu_issue_state_t in miriscv_mdu_pkg, alongside the MDU opcodes; XLEN SHALL come from miriscv_pkg.
REQ-032 SHALL be a single module with no sub-modules; it instantiates beside miriscv_mdu, upstream of it.

Verification
REQ-033 SHALL cover: MUL a=3, b=5, MDU stall for 2 cycles -> wb_valid_o in cycle 4 after issue, wb_data_o=15, issue_stall_o high until retire.
REQ-034 SHALL cover: DIVU a=100, b=7 with wb_stall_i held 3 cycles in DONE -> wb_data_o=14 stable for 4 cycles, mdu_req_o=0, mdu_keep_o=1.
REQ-035 SHALL cover: ex_flush_i in the 2nd BUSY cycle -> one-cycle mdu_kill_o pulse, IDLE next, no wb_valid_o.
REQ-036 SHALL cover: back-to-back MUL 2*2 then MULHU 0xFFFFFFFF*2 with wb_stall_i=0 -> results 4 then 1, no IDLE cycle between them.
REQ-037 SHALL cover: mdu_stall_req_i held high, TIMEOUT_CYCLES=8 -> kill pulse on the 8th BUSY cycle, wb_err_o=1, wb_data_o=0.
REQ-038 SHALL cover: arstn_i low during BUSY -> all outputs 0 at once; after release, state IDLE and no stale wb_valid_o.

Source files
------------

// File: rtl/miriscv_mdu_pkg.sv
// ----------------------------------------------------------------------------
// miriscv_mdu_pkg
// Shared definitions for the multiply/divide unit and its issue stage:
//   MDU_OP_WIDTH      : width of the MDU opcode field
//   MDU_*             : RV32M opcode encodings understood by miriscv_mdu
//   mdu_issue_state_t : state of the issue stage in front of the MDU
// ----------------------------------------------------------------------------
package miriscv_mdu_pkg;

    localparam int MDU_OP_WIDTH = 3;

    localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // nothing in flight, ready to accept
        BUSY = 2'd1,   // operation handed to the MDU, waiting for it
        DONE = 2'd2    // result held for writeback
    } mdu_issue_state_t;

endpackage : miriscv_mdu_pkg

// File: rtl/miriscv_pkg.sv
// ----------------------------------------------------------------------------
// miriscv_pkg
// Core-wide constants shared by every miriscv block.
//   XLEN : integer register / datapath width in bits.
// ----------------------------------------------------------------------------
package miriscv_pkg;

    localparam int XLEN = 32;

endpackage : miriscv_pkg

// File: rtl/miriscv_mdu_issue.sv
// ----------------------------------------------------------------------------
// miriscv_mdu_issue
// Issue/hand-off stage that sits between the execute stage and miriscv_mdu.
// It captures one MDU instruction, keeps the MDU operands stable while the
// MDU works, holds the result until writeback takes it, and aborts the
// operation on a pipeline flush or when the MDU stalls for too long.
//
// Parameters
//   TIMEOUT_CYCLES : BUSY cycles allowed before the operation is aborted
//   RD_W           : destination register index width
// Ports
//   clk_i, arstn_i          : clock (rising edge), async active-low reset
//   ex_valid_i/op/a/b/rd    : instruction offered by the execute stage
//   ex_flush_i              : cancels the instruction in flight
//   wb_stall_i              : writeback cannot take a result this cycle
//   mdu_stall_req_i         : MDU still working
//   mdu_result_i            : MDU result, valid when mdu_stall_req_i is 0
//   mdu_req_o/op/port_a/b   : request and operands towards the MDU
//   mdu_kill_o              : abort the MDU operation (flush or timeout)
//   mdu_keep_o              : MDU must keep its result (held in DONE)
//   issue_stall_o           : execute must hold its instruction
//   wb_valid_o/rd/data/err  : result towards writeback (err = timed out)
// ----------------------------------------------------------------------------
module miriscv_mdu_issue
    import miriscv_pkg::*;
    import miriscv_mdu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RD_W           = 5
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    ex_valid_i,
    input  logic [MDU_OP_WIDTH-1:0] ex_op_i,
    input  logic [XLEN-1:0]         ex_a_i,
    input  logic [XLEN-1:0]         ex_b_i,
    input  logic [RD_W-1:0]         ex_rd_i,
    input  logic                    ex_flush_i,
    input  logic                    wb_stall_i,
    input  logic                    mdu_stall_req_i,
    input  logic [XLEN-1:0]         mdu_result_i,
    output logic                    mdu_req_o,
    output logic [MDU_OP_WIDTH-1:0] mdu_op_o,
    output logic [XLEN-1:0]         mdu_port_a_o,
    output logic [XLEN-1:0]         mdu_port_b_o,
    output logic                    mdu_kill_o,
    output logic                    mdu_keep_o,
    output logic                    issue_stall_o,
    output logic                    wb_valid_o,
    output logic [RD_W-1:0]         wb_rd_o,
    output logic [XLEN-1:0]         wb_data_o,
    output logic                    wb_err_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    // The counter holds the number of BUSY cycles already spent, so the
    // last allowed BUSY cycle is the one that sees TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mdu_issue_state_t        state_r;
    mdu_issue_state_t        state_next_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [MDU_OP_WIDTH-1:0] op_r;
    logic [XLEN-1:0]         a_r;
    logic [XLEN-1:0]         b_r;
    logic [RD_W-1:0]         rd_r;
    logic [XLEN-1:0]         data_r;
    logic                    err_r;

    logic                    accept_s;
    logic                    complete_s;
    logic                    timeout_s;

    // A new instruction is taken when the stage is empty or its held result
    // retires this very cycle; a flush always wins over a new issue.
    assign accept_s   = ex_valid_i && !ex_flush_i &&
                        ((state_r == IDLE) || ((state_r == DONE) && !wb_stall_i));
    assign complete_s = (state_r == BUSY) && !ex_flush_i && !mdu_stall_req_i;
    assign timeout_s  = (state_r == BUSY) && !ex_flush_i && mdu_stall_req_i &&
                        (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: flush > completion/timeout > new issue.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (ex_flush_i) begin
                    state_next_s = IDLE;
                end else if (complete_s || timeout_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (ex_flush_i) begin
                    state_next_s = IDLE;
                end else if (wb_stall_i) begin
                    state_next_s = DONE;
                end else if (accept_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State-decoded control outputs.
    always_comb begin
        mdu_req_o     = 1'b0;
        mdu_kill_o    = 1'b0;
        mdu_keep_o    = 1'b0;
        wb_valid_o    = 1'b0;
        issue_stall_o = ex_valid_i;
        case (state_r)
            IDLE: begin
                issue_stall_o = 1'b0;
            end
            BUSY: begin
                mdu_req_o  = 1'b1;
                mdu_kill_o = ex_flush_i || timeout_s;
            end
            DONE: begin
                mdu_keep_o    = 1'b1;
                wb_valid_o    = 1'b1;
                issue_stall_o = ex_valid_i && wb_stall_i;
            end
            default: begin
                issue_stall_o = ex_valid_i;
            end
        endcase
    end

    // BUSY cycle counter, restarted on every issue and saturating.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cnt_r <= '0;
        end else if (accept_s) begin
            cnt_r <= '0;
        end else if ((state_r == BUSY) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Captured instruction, result and error flag.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            rd_r   <= '0;
            data_r <= '0;
            err_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                op_r  <= ex_op_i;
                a_r   <= ex_a_i;
                b_r   <= ex_b_i;
                rd_r  <= ex_rd_i;
                err_r <= 1'b0;
            end
            if (complete_s) begin
                data_r <= mdu_result_i;
            end else if (timeout_s) begin
                data_r <= '0;
                err_r  <= 1'b1;
            end
        end
    end

    assign mdu_op_o     = op_r;
    assign mdu_port_a_o = a_r;
    assign mdu_port_b_o = b_r;
    assign wb_rd_o      = rd_r;
    assign wb_data_o    = data_r;
    assign wb_err_o     = err_r;

endmodule : miriscv_mdu_issue

// File: tb/tb_miriscv_mdu_issue.sv
// ----------------------------------------------------------------------------
// tb_miriscv_mdu_issue
// Self-checking bench for miriscv_mdu_issue. The bench plays the role of the
// MDU (returning RV32M results computed here) and keeps a transaction-level
// model of the issue stage that predicts every output on every cycle.
// ----------------------------------------------------------------------------
module tb_miriscv_mdu_issue
    import miriscv_pkg::*;
    import miriscv_mdu_pkg::*;
;
    localparam int TO = 8;

    logic        clk;
    logic        arstn_i;
    logic        ex_valid_i;
    logic [2:0]  ex_op_i;
    logic [31:0] ex_a_i;
    logic [31:0] ex_b_i;
    logic [4:0]  ex_rd_i;
    logic        ex_flush_i;
    logic        wb_stall_i;
    logic        mdu_stall_req_i;
    logic [31:0] mdu_result_i;
    logic        mdu_req_o;
    logic [2:0]  mdu_op_o;
    logic [31:0] mdu_port_a_o;
    logic [31:0] mdu_port_b_o;
    logic        mdu_kill_o;
    logic        mdu_keep_o;
    logic        issue_stall_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    miriscv_mdu_issue #(.TIMEOUT_CYCLES(TO), .RD_W(5)) dut (
        .clk_i(clk), .arstn_i(arstn_i),
        .ex_valid_i(ex_valid_i), .ex_op_i(ex_op_i), .ex_a_i(ex_a_i), .ex_b_i(ex_b_i),
        .ex_rd_i(ex_rd_i), .ex_flush_i(ex_flush_i), .wb_stall_i(wb_stall_i),
        .mdu_stall_req_i(mdu_stall_req_i), .mdu_result_i(mdu_result_i),
        .mdu_req_o(mdu_req_o), .mdu_op_o(mdu_op_o), .mdu_port_a_o(mdu_port_a_o),
        .mdu_port_b_o(mdu_port_b_o), .mdu_kill_o(mdu_kill_o), .mdu_keep_o(mdu_keep_o),
        .issue_stall_o(issue_stall_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .wb_err_o(wb_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RV32M reference arithmetic.
    function automatic logic [31:0] mdu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            MDU_MUL:    begin p = {32'd0, a} * {32'd0, b};             return p[31:0];  end
            MDU_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            MDU_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
            MDU_MULHU:  begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
            MDU_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                else return 32'(sa / sb);
            end
            MDU_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else return a / b;
            end
            MDU_REM: begin
                if (b == 32'd0) return a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                else return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return a;
                else return a % b;
            end
        endcase
    endfunction

    // Transaction view of the stage: is an instruction with the MDU, is a
    // result waiting for writeback, and how long has the MDU been at it.
    typedef struct packed {
        bit          active;
        bit          ready;
        int          waited;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic [4:0]  rd;
        bit          err;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t model_step(input mdl_t m);
        mdl_t n;
        bit   room;
        bit   take;
        n    = m;
        room = (!m.active && !m.ready) || (m.ready && !wb_stall_i);
        take = ex_valid_i && !ex_flush_i && room;
        if (m.active) begin
            if (ex_flush_i) begin
                n.active = 1'b0;
            end else if (!mdu_stall_req_i) begin
                n.active = 1'b0;
                n.ready  = 1'b1;
                n.data   = mdu_ref(m.op, m.a, m.b);
            end else if (m.waited + 1 == TO) begin
                n.active = 1'b0;
                n.ready  = 1'b1;
                n.data   = 32'd0;
                n.err    = 1'b1;
            end else begin
                n.waited = m.waited + 1;
            end
        end else if (m.ready && (ex_flush_i || !wb_stall_i)) begin
            n.ready = 1'b0;
        end
        if (take) begin
            n.active = 1'b1;
            n.ready  = 1'b0;
            n.waited = 0;
            n.op     = ex_op_i;
            n.a      = ex_a_i;
            n.b      = ex_b_i;
            n.rd     = ex_rd_i;
            n.err    = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge arstn_i) begin
        if (!arstn_i) mdl <= '0;
        else          mdl <= model_step(mdl);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin : compare
        bit room;
        bit kill_exp;
        room     = (!mdl.active && !mdl.ready) || (mdl.ready && !wb_stall_i);
        kill_exp = mdl.active && (ex_flush_i || (mdu_stall_req_i && (mdl.waited + 1 == TO)));
        chk("mdu_req",     32'(mdu_req_o),     32'(mdl.active));
        chk("mdu_op",      32'(mdu_op_o),      32'(mdl.op));
        chk("mdu_port_a",  mdu_port_a_o,       mdl.a);
        chk("mdu_port_b",  mdu_port_b_o,       mdl.b);
        chk("mdu_kill",    32'(mdu_kill_o),    32'(kill_exp));
        chk("mdu_keep",    32'(mdu_keep_o),    32'(mdl.ready));
        chk("issue_stall", 32'(issue_stall_o), 32'(ex_valid_i && !room));
        chk("wb_valid",    32'(wb_valid_o),    32'(mdl.ready));
        chk("wb_rd",       32'(wb_rd_o),       32'(mdl.rd));
        chk("wb_data",     wb_data_o,          mdl.data);
        chk("wb_err",      32'(wb_err_o),      32'(mdl.err));
    end

    // Drive one cycle of inputs just after the edge; the MDU answers with the
    // arithmetic result of whatever operands the DUT presents, or noise while
    // it reports a stall.
    task automatic set_in(input bit v, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input bit fl,
                          input bit ws, input bit st);
        @(posedge clk);
        #1;
        ex_valid_i      = v;
        ex_op_i         = op;
        ex_a_i          = a;
        ex_b_i          = b;
        ex_rd_i         = rd;
        ex_flush_i      = fl;
        wb_stall_i      = ws;
        mdu_stall_req_i = st;
        mdu_result_i    = st ? $urandom() : mdu_ref(mdu_op_o, mdu_port_a_o, mdu_port_b_o);
        #1;
    endtask

    task automatic idle_in(input bit ws, input bit st);
        set_in(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, ws, st);
    endtask

    task automatic chk_all_zero(input string tag);
        logic [31:0] ored;
        ored = 32'(mdu_req_o) | 32'(mdu_op_o) | mdu_port_a_o | mdu_port_b_o |
               32'(mdu_kill_o) | 32'(mdu_keep_o) | 32'(issue_stall_o) | 32'(wb_valid_o) |
               32'(wb_rd_o) | wb_data_o | 32'(wb_err_o);
        chk(tag, ored, 32'd0);
    endtask

    initial begin
        arstn_i = 1'b0;
        ex_valid_i = 1'b0; ex_op_i = 3'd0; ex_a_i = 32'd0; ex_b_i = 32'd0; ex_rd_i = 5'd0;
        ex_flush_i = 1'b0; wb_stall_i = 1'b0; mdu_stall_req_i = 1'b0; mdu_result_i = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset_outputs");
        @(posedge clk);
        #1;
        arstn_i = 1'b1;

        // MUL 3*5, MDU stalls two cycles; a second instruction waits behind it.
        set_in(1'b1, MDU_MUL, 32'd3, 32'd5, 5'd1, 1'b0, 1'b0, 1'b1);
        chk("mul_issue_no_stall", 32'(issue_stall_o), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            set_in(1'b1, MDU_MUL, 32'd6, 32'd7, 5'd2, 1'b0, 1'b0, (k < 3) ? 1'b1 : 1'b0);
            chk("mul_busy_stall", 32'(issue_stall_o), 32'd1);
            chk("mul_busy_req", 32'(mdu_req_o), 32'd1);
            chk("mul_no_valid_yet", 32'(wb_valid_o), 32'd0);
        end
        set_in(1'b1, MDU_MUL, 32'd6, 32'd7, 5'd2, 1'b0, 1'b0, 1'b0);
        chk("mul_valid_c4", 32'(wb_valid_o), 32'd1);
        chk("mul_data_15", wb_data_o, 32'd15);
        chk("mul_rd", 32'(wb_rd_o), 32'd1);
        chk("mul_retire_unstall", 32'(issue_stall_o), 32'd0);
        idle_in(1'b0, 1'b0);
        idle_in(1'b0, 1'b0);
        chk("mul_second_42", wb_data_o, 32'd42);
        idle_in(1'b0, 1'b0);

        // DIVU 100/7 held in DONE by writeback for three cycles.
        set_in(1'b1, MDU_DIVU, 32'd100, 32'd7, 5'd3, 1'b0, 1'b0, 1'b0);
        idle_in(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle_in((k < 3) ? 1'b1 : 1'b0, 1'b0);
            chk("divu_data_14", wb_data_o, 32'd14);
            chk("divu_valid", 32'(wb_valid_o), 32'd1);
            chk("divu_req_low", 32'(mdu_req_o), 32'd0);
            chk("divu_keep", 32'(mdu_keep_o), 32'd1);
        end
        idle_in(1'b0, 1'b0);
        chk("divu_retired", 32'(wb_valid_o), 32'd0);

        // Flush in the second BUSY cycle.
        set_in(1'b1, MDU_MUL, 32'd9, 32'd9, 5'd8, 1'b0, 1'b0, 1'b1);
        idle_in(1'b0, 1'b1);
        chk("flush_no_kill_yet", 32'(mdu_kill_o), 32'd0);
        set_in(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        chk("flush_kill", 32'(mdu_kill_o), 32'd1);
        idle_in(1'b0, 1'b0);
        chk("flush_kill_one_cycle", 32'(mdu_kill_o), 32'd0);
        chk("flush_idle_req", 32'(mdu_req_o), 32'd0);
        chk("flush_no_valid", 32'(wb_valid_o), 32'd0);
        idle_in(1'b0, 1'b0);
        chk("flush_no_valid_later", 32'(wb_valid_o), 32'd0);

        // Back-to-back MUL 2*2 then MULHU 0xFFFFFFFF*2.
        set_in(1'b1, MDU_MUL, 32'd2, 32'd2, 5'd4, 1'b0, 1'b0, 1'b0);
        set_in(1'b1, MDU_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("b2b_hold", 32'(issue_stall_o), 32'd1);
        set_in(1'b1, MDU_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("b2b_first_4", wb_data_o, 32'd4);
        chk("b2b_accept", 32'(issue_stall_o), 32'd0);
        idle_in(1'b0, 1'b0);
        chk("b2b_busy_no_gap", 32'(mdu_req_o), 32'd1);
        chk("b2b_port_a", mdu_port_a_o, 32'hFFFF_FFFF);
        idle_in(1'b0, 1'b0);
        chk("b2b_second_1", wb_data_o, 32'd1);
        chk("b2b_second_rd", 32'(wb_rd_o), 32'd5);
        idle_in(1'b0, 1'b0);

        // Timeout: MDU never finishes.
        set_in(1'b1, MDU_DIV, 32'd50, 32'd5, 5'd6, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= TO; k++) begin
            idle_in(1'b0, 1'b1);
            chk("to_kill", 32'(mdu_kill_o), (k == TO) ? 32'd1 : 32'd0);
        end
        idle_in(1'b0, 1'b1);
        chk("to_valid", 32'(wb_valid_o), 32'd1);
        chk("to_err", 32'(wb_err_o), 32'd1);
        chk("to_data_zero", wb_data_o, 32'd0);
        chk("to_kill_done", 32'(mdu_kill_o), 32'd0);
        set_in(1'b1, MDU_MUL, 32'd1, 32'd1, 5'd7, 1'b0, 1'b0, 1'b0);
        idle_in(1'b0, 1'b0);
        chk("to_err_cleared", 32'(wb_err_o), 32'd0);
        idle_in(1'b0, 1'b0);
        chk("to_next_data", wb_data_o, 32'd1);
        idle_in(1'b0, 1'b0);

        // Asynchronous reset while BUSY.
        set_in(1'b1, MDU_REMU, 32'd77, 32'd10, 5'd9, 1'b0, 1'b0, 1'b1);
        set_in(1'b1, MDU_MUL, 32'd4, 32'd4, 5'd10, 1'b0, 1'b0, 1'b1);
        #1;
        arstn_i = 1'b0;
        #1;
        chk_all_zero("reset_mid_busy");
        set_in(1'b1, MDU_MUL, 32'd4, 32'd4, 5'd10, 1'b0, 1'b0, 1'b0);
        chk_all_zero("reset_held");
        arstn_i = 1'b1;
        #1;
        chk("reset_idle_accepts", 32'(issue_stall_o), 32'd0);
        idle_in(1'b0, 1'b0);
        chk("reset_no_stale_valid", 32'(wb_valid_o), 32'd0);
        idle_in(1'b0, 1'b0);
        chk("reset_new_op_16", wb_data_o, 32'd16);
        idle_in(1'b0, 1'b0);

        // Randomised traffic, with periods of long MDU stalls to hit timeouts.
        for (int i = 0; i < 2000; i++) begin
            bit long_st;
            long_st = ((i / 150) % 3) == 2;
            set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(),
                   5'($urandom_range(0, 31)),
                   long_st ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 9) < 3),
                   long_st ? ($urandom_range(0, 19) != 0) : 1'($urandom_range(0, 1)));
        end
        repeat (3) idle_in(1'b0, 1'b0);

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_miriscv_mdu_issue
